mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified byte-addressed memory port between instruction fetch (I) and the
//  MEM-stage load/store (D). One outstanding access at a time; each requester gets grant/response
//  handshakes and a stall source. Sits between CPU (pc / ex_mem_* signals) and MEM.
// PARAMETERS
//  DATA_LEN    32   data/address width
//  STARVE_MAX  4    consecutive D grants allowed while i_req pending before I is forced (1..15)
//  TIMEOUT     16   max cycles in a BUSY state waiting for m_rvalid (2..255)
// PORTS
//  clk        in   1         clock, all state on rising edge
//  reset      in   1         asynchronous, active-low; clears all state
//  i_req      in   1         fetch request; held until i_gnt
//  i_addr     in   DATA_LEN  fetch address (pc)
//  i_gnt      out  1         fetch accepted this cycle
//  i_rvalid   out  1         i_rdata valid (one cycle)
//  i_rdata    out  DATA_LEN  fetched instruction
//  d_req      in   1         data request; held with fn/addr/wdata stable until d_gnt
//  d_fn       in   3         `MEM_* code from define.vh (LB/LH/LW/LBU/LHU/SB/SH/SW)
//  d_addr     in   DATA_LEN  data address (ex_mem_alu_out)
//  d_wdata    in   DATA_LEN  store data (ex_mem_rs2_data)
//  d_gnt      out  1         data request accepted this cycle
//  d_rvalid   out  1         load data / store ack valid (one cycle)
//  d_rdata    out  DATA_LEN  load data (zero for stores)
//  m_req      out  1         memory access issue strobe (one cycle per access)
//  m_fn       out  3         code to memory; `MEM_LW for fetches
//  m_addr     out  DATA_LEN  memory address
//  m_wdata    out  DATA_LEN  memory write data (zero for fetches/loads)
//  m_rvalid   in   1         memory completion strobe (loads and stores)
//  m_rdata    in   DATA_LEN  memory read data
//  err        out  1         sticky timeout flag
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, d_streak=0, err=0; all outputs 0.
//  - States: IDLE, BUSY_I, BUSY_D. Only IDLE issues; i_gnt/d_gnt/m_req asserted only in IDLE.
//  - IDLE arbitration (combinational, same cycle): D wins if d_req, unless i_req && d_streak==STARVE_MAX,
//    then I wins. Winner: gnt=1, m_req=1, m_fn/m_addr/m_wdata driven from winner; next state BUSY_x.
//    No request: stay IDLE, m_req=0, m_fn/m_addr/m_wdata=0.
//  - d_streak: +1 on each D grant while i_req=1 (saturates at STARVE_MAX); cleared on any I grant or
//    on a D grant with i_req=0.
//  - BUSY_x: wait for m_rvalid. On m_rvalid: x_rvalid=1, x_rdata=m_rdata (d_rdata=0 for store fn),
//    other requester's rvalid=0; next state IDLE. Min turnaround: issue, >=1 BUSY cycle, IDLE => an
//    access occupies >=2 cycles; one idle bubble between accesses is required.
//  - m_rvalid in IDLE is ignored (no rvalid out, no error).
//  - Timeout: busy counter starts at 0 on entry to BUSY; if it reaches TIMEOUT-1 without m_rvalid,
//    err<=1 (sticky until reset), state<=IDLE, no rvalid to requester; requester must re-request.
//  - Simultaneous i_req and d_req with d_streak<STARVE_MAX: D granted, I waits (i_gnt=0).
//  - Requests arriving during BUSY are not granted until IDLE; req must be held (not checked).
//  - Reset mid-access: returns to IDLE immediately; in-flight response discarded.
//  - Stall for CPU: fetch stalls while i_req && !i_rvalid; MEM stage stalls while d_req or BUSY_D.
// TESTING
//  1. Reset low mid-BUSY_D -> next edge: all outputs 0, err=0; late m_rvalid produces no d_rvalid.
//  2. i_req only, addr 0x100, memory returns 0x00000013 one cycle later -> i_gnt+m_req(fn LW,addr
//     0x100) in cycle 0, i_rvalid=1 i_rdata=0x13 in cycle 1, IDLE in cycle 2.
//  3. i_req and d_req (LW, 0x2000) together -> d_gnt first, i_gnt only after d_rvalid + IDLE cycle.
//  4. i_req held, d_req held 6 accesses, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D.
//  5. SW 0xDEADBEEF to 0x40 -> m_wdata=0xDEADBEEF, m_fn=SW; on ack d_rvalid=1, d_rdata=0.
//  6. Issue D, never assert m_rvalid, TIMEOUT=16 -> err=1 after 16 BUSY cycles, IDLE, next req granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed memory port between instruction fetch (I) and MEM-stage load/store (D).
// One access in flight at a time; grants and issue happen only from IDLE, responses are routed back.
module mem_port_arbiter #(
   parameter int DATA_LEN   = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [DATA_LEN-1:0] i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_LEN-1:0] i_rdata,
   input  logic                d_req,
   input  logic [2:0]          d_fn,
   input  logic [DATA_LEN-1:0] d_addr,
   input  logic [DATA_LEN-1:0] d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_LEN-1:0] d_rdata,
   output logic                m_req,
   output logic [2:0]          m_fn,
   output logic [DATA_LEN-1:0] m_addr,
   output logic [DATA_LEN-1:0] m_wdata,
   input  logic                m_rvalid,
   input  logic [DATA_LEN-1:0] m_rdata,
   output logic                err
);

   localparam logic [2:0] MEM_LW = 3'd2;
   localparam logic [2:0] MEM_SB = 3'd5;
   localparam logic [2:0] MEM_SH = 3'd6;
   localparam logic [2:0] MEM_SW = 3'd7;

   localparam logic [3:0]          STREAK_MAX = 4'(STARVE_MAX);
   localparam logic [7:0]          BUSY_LAST  = 8'(TIMEOUT - 1);
   localparam logic [DATA_LEN-1:0] ZERO_W     = {DATA_LEN{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } state_t;

   state_t      state_r, state_s;
   logic [3:0]  d_streak_r, d_streak_s;
   logic [7:0]  busy_cnt_r, busy_cnt_s;
   logic        d_store_r, d_store_s;
   logic        err_r, err_s;
   logic        grant_d_s, grant_i_s;

   function automatic logic is_store(input logic [2:0] fn);
      is_store = (fn == MEM_SB) || (fn == MEM_SH) || (fn == MEM_SW);
   endfunction

   // Arbitration, issue, response routing and next-state logic; all outputs forced low in reset.
   always_comb begin
      state_s    = state_r;
      d_streak_s = d_streak_r;
      busy_cnt_s = busy_cnt_r;
      d_store_s  = d_store_r;
      err_s      = err_r;
      grant_d_s  = 1'b0;
      grant_i_s  = 1'b0;
      i_gnt      = 1'b0;
      i_rvalid   = 1'b0;
      i_rdata    = ZERO_W;
      d_gnt      = 1'b0;
      d_rvalid   = 1'b0;
      d_rdata    = ZERO_W;
      m_req      = 1'b0;
      m_fn       = 3'd0;
      m_addr     = ZERO_W;
      m_wdata    = ZERO_W;
      if (reset) begin
         case (state_r)
            ST_IDLE: begin
               grant_d_s  = d_req && !(i_req && (d_streak_r == STREAK_MAX));
               grant_i_s  = i_req && !grant_d_s;
               busy_cnt_s = 8'd0;
               if (grant_d_s) begin
                  d_gnt     = 1'b1;
                  m_req     = 1'b1;
                  m_fn      = d_fn;
                  m_addr    = d_addr;
                  m_wdata   = is_store(d_fn) ? d_wdata : ZERO_W;
                  d_store_s = is_store(d_fn);
                  state_s   = ST_BUSY_D;
                  // Streak only grows while fetch is actually being held off.
                  if (i_req) begin
                     d_streak_s = (d_streak_r == STREAK_MAX) ? d_streak_r : d_streak_r + 4'd1;
                  end else begin
                     d_streak_s = 4'd0;
                  end
               end else if (grant_i_s) begin
                  i_gnt      = 1'b1;
                  m_req      = 1'b1;
                  m_fn       = MEM_LW;
                  m_addr     = i_addr;
                  d_streak_s = 4'd0;
                  state_s    = ST_BUSY_I;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_BUSY_I, ST_BUSY_D: begin
               if (m_rvalid) begin
                  state_s = ST_IDLE;
                  if (state_r == ST_BUSY_I) begin
                     i_rvalid = 1'b1;
                     i_rdata  = m_rdata;
                  end else begin
                     d_rvalid = 1'b1;
                     d_rdata  = d_store_r ? ZERO_W : m_rdata;
                  end
               end else if (busy_cnt_r == BUSY_LAST) begin
                  err_s   = 1'b1;
                  state_s = ST_IDLE;
               end else begin
                  busy_cnt_s = busy_cnt_r + 8'd1;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end else begin
         state_s = ST_IDLE;
      end
   end

   // State registers; asserting reset abandons any in-flight access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         d_streak_r <= 4'd0;
         busy_cnt_r <= 8'd0;
         d_store_r  <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         d_streak_r <= d_streak_s;
         busy_cnt_r <= busy_cnt_s;
         d_store_r  <= d_store_s;
         err_r      <= err_s;
      end
   end

   assign err = err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int DL = 32;
   localparam int SMAX = 4;
   localparam int TMO = 16;
   localparam logic [2:0] F_LW = 3'd2, F_LBU = 3'd3, F_SB = 3'd5, F_SW = 3'd7;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req, d_req, m_rvalid;
   logic [DL-1:0] i_addr, d_addr, d_wdata, m_rdata;
   logic [2:0]    d_fn;
   logic          i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, err;
   logic [DL-1:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic [2:0]    m_fn;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_LEN(DL), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_fn(d_fn), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_fn(m_fn), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_fn = 3'd0; d_addr = 32'h0;
      d_wdata = 32'h0; m_rvalid = 1'b0; m_rdata = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   function automatic logic [136:0] dut_outs();
      return {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_fn, m_addr, m_wdata, err};
   endfunction

   typedef struct {
      logic        i_req, d_req;
      logic [2:0]  fn;
      logic [31:0] i_addr, d_addr, wdata, rdata;
      logic        e_i_gnt, e_d_gnt;
      logic [2:0]  e_fn;
      logic [31:0] e_addr, e_wdata;
      logic        e_i_rv, e_d_rv;
      logic [31:0] e_i_rdata, e_d_rdata;
   } vec_t;

   vec_t tv[6];

   // reference model state (transaction level)
   bit          busy, own_d, store, merr, ir, dr;
   int          waited, streak, lat, n;
   logic [31:0] ia, da, dw;
   logic [2:0]  dfn;
   logic        eig, edg, eirv, edrv;
   logic [31:0] eird, edrd, ea, ew;
   logic [2:0]  efn;
   logic [1:0]  exp_order[7];
   bit          rv_seen;

   initial begin
      reset = 1'b0;
      idle_inputs();

      // ---------------- table-driven single accesses ----------------
      tv[0] = '{1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 32'h0, 32'h13,
                1'b1, 1'b0, F_LW, 32'h100, 32'h0, 1'b1, 1'b0, 32'h13, 32'h0};
      tv[1] = '{1'b0, 1'b1, F_SW, 32'h0, 32'h40, 32'hDEADBEEF, 32'h12345678,
                1'b0, 1'b1, F_SW, 32'h40, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 32'h0};
      tv[2] = '{1'b1, 1'b1, F_LW, 32'h104, 32'h2000, 32'h55, 32'hCAFEF00D,
                1'b0, 1'b1, F_LW, 32'h2000, 32'h0, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D};
      tv[3] = '{1'b0, 1'b1, F_LBU, 32'h0, 32'h3, 32'h77, 32'hFF,
                1'b0, 1'b1, F_LBU, 32'h3, 32'h0, 1'b0, 1'b1, 32'h0, 32'hFF};
      tv[4] = '{1'b0, 1'b1, F_SB, 32'h0, 32'h7, 32'hAB, 32'h9999,
                1'b0, 1'b1, F_SB, 32'h7, 32'hAB, 1'b0, 1'b1, 32'h0, 32'h0};
      tv[5] = '{1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h4242,
                1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};

      do_reset();
      check("reset_state_outs", 160'(|dut_outs()), 160'd0);
      for (int k = 0; k < 6; k++) begin
         do_reset();
         i_req = tv[k].i_req; i_addr = tv[k].i_addr; d_req = tv[k].d_req;
         d_fn = tv[k].fn; d_addr = tv[k].d_addr; d_wdata = tv[k].wdata;
         #3;
         check($sformatf("vec%0d_issue", k), {i_gnt, d_gnt, m_req, m_fn, m_addr, m_wdata},
               {tv[k].e_i_gnt, tv[k].e_d_gnt, tv[k].e_i_gnt | tv[k].e_d_gnt,
                tv[k].e_fn, tv[k].e_addr, tv[k].e_wdata});
         tick();
         i_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b1; m_rdata = tv[k].rdata;
         #3;
         check($sformatf("vec%0d_resp", k), {i_rvalid, i_rdata, d_rvalid, d_rdata, err},
               {tv[k].e_i_rv, tv[k].e_i_rdata, tv[k].e_d_rv, tv[k].e_d_rdata, 1'b0});
         tick();
         m_rvalid = 1'b0;
      end

      // ---------------- reset in the middle of a D access ----------------
      do_reset();
      d_req = 1'b1; d_fn = F_LW; d_addr = 32'h2000;
      tick();
      d_req = 1'b0;
      reset = 1'b0;
      #2;
      check("rst_mid_outs_async", 160'(|dut_outs()), 160'd0);
      tick();
      check("rst_mid_outs_edge", 160'(|dut_outs()), 160'd0);
      reset = 1'b1;
      tick();
      m_rvalid = 1'b1; m_rdata = 32'h5A5A;
      #3;
      check("rst_late_rvalid", {d_rvalid, i_rvalid, err}, 3'b000);
      tick();
      m_rvalid = 1'b0;

      // ---------------- simultaneous requests: D first, I after bubble ----------------
      do_reset();
      i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_fn = F_LW; d_addr = 32'h2000;
      #3;
      check("both_d_first", {i_gnt, d_gnt}, 2'b01);
      tick();
      d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h11;
      #3;
      check("both_d_ack_no_i", {i_gnt, d_rvalid, d_rdata}, {1'b0, 1'b1, 32'h11});
      tick();
      m_rvalid = 1'b0;
      #3;
      check("both_i_after", {i_gnt, m_fn, m_addr}, {1'b1, F_LW, 32'h100});
      tick();
      i_req = 1'b0; m_rvalid = 1'b1;
      tick();
      m_rvalid = 1'b0;

      // ---------------- starvation guard ----------------
      exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
      do_reset();
      i_req = 1'b1; i_addr = 32'h500; d_req = 1'b1; d_fn = F_LW; d_addr = 32'h600;
      for (int k = 0; k < 7; k++) begin
         #3;
         check($sformatf("starve_order_%0d", k), {i_gnt, d_gnt}, exp_order[k]);
         tick();
         m_rvalid = 1'b1;
         tick();
         m_rvalid = 1'b0;
      end
      idle_inputs();

      // ---------------- timeout ----------------
      do_reset();
      d_req = 1'b1; d_fn = F_LW; d_addr = 32'h80;
      #3;
      check("tmo_issue", d_gnt, 1'b1);
      tick();
      d_req = 1'b0;
      n = 0; rv_seen = 1'b0;
      while (err !== 1'b1 && n < 40) begin
         rv_seen = rv_seen | d_rvalid | i_rvalid;
         tick();
         n++;
      end
      check("tmo_busy_cycles", n, 16);
      check("tmo_no_rvalid", rv_seen, 1'b0);
      d_req = 1'b1; d_fn = F_SB; d_addr = 32'h84; d_wdata = 32'h1;
      #3;
      check("tmo_regrant", {d_gnt, err}, 2'b11);
      tick();
      d_req = 1'b0; m_rvalid = 1'b1;
      tick();
      m_rvalid = 1'b0;
      check("tmo_err_sticky", err, 1'b1);
      do_reset();
      check("tmo_err_cleared", err, 1'b0);

      // ---------------- randomized traffic vs reference model ----------------
      do_reset();
      busy = 0; own_d = 0; store = 0; merr = 0; waited = 0; streak = 0; lat = 0;
      ir = 0; dr = 0; ia = 0; da = 0; dw = 0; dfn = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!ir && $urandom_range(0, 2) == 0) begin
            ir = 1; ia = $urandom;
         end
         if (!dr && $urandom_range(0, 2) == 0) begin
            dr = 1; dfn = 3'($urandom_range(0, 7)); da = $urandom; dw = $urandom;
         end
         i_req = ir; i_addr = ia; d_req = dr; d_fn = dfn; d_addr = da; d_wdata = dw;
         m_rvalid = busy ? (lat == 0) : ($urandom_range(0, 7) == 0);
         m_rdata = $urandom;
         #3;
         eig = 0; edg = 0; eirv = 0; edrv = 0; eird = 0; edrd = 0; efn = 0; ea = 0; ew = 0;
         if (!busy) begin
            edg = dr && !(ir && streak == SMAX);
            eig = ir && !edg;
            if (edg) begin
               efn = dfn; ea = da; ew = (dfn >= F_SB) ? dw : 32'h0;
            end else if (eig) begin
               efn = F_LW; ea = ia;
            end
         end else if (m_rvalid) begin
            if (own_d) begin
               edrv = 1; edrd = store ? 32'h0 : m_rdata;
            end else begin
               eirv = 1; eird = m_rdata;
            end
         end
         check("rand_cycle", dut_outs(),
               {eig, eirv, eird, edg, edrv, edrd, eig | edg, efn, ea, ew, merr});
         if (!busy) begin
            if (edg || eig) begin
               busy = 1; own_d = edg; store = edg && (dfn >= F_SB); waited = 0;
               lat = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 20);
               if (edg && ir) streak = (streak < SMAX) ? streak + 1 : streak;
               else streak = 0;
               if (edg) dr = 0;
               else ir = 0;
            end
         end else if (m_rvalid) begin
            busy = 0;
         end else if (waited + 1 == TMO) begin
            busy = 0; merr = 1;
         end else begin
            waited++; lat--;
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
